// File: rtl/data_mem_stall.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline with `stall` for LATENCY cycles per access.
// Optional misaligned-access detection is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_stall #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              halt,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int OFF = $clog2(DATA_W / 8);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [3:0]            count;
  logic                  opWr;
  logic [ADDR_W-1:0]     addrQ;
  logic [DATA_W-1:0]     wdataQ;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  errQ;

  logic                  accept;
  logic                  finish;
  logic                  accWr;
  logic [ADDR_W-1:0]     accAddr;
  logic [DATA_W-1:0]     accData;
  logic [DEPTH_LOG2-1:0] accIdx;
  logic                  accMis;

  assign accept = (req_rd | req_wr) & ~halt & ((state == IDLE) | (state == DONE));
  assign stall  = (state == BUSY) | accept;
  assign err    = errQ;

  // With a single-cycle latency the access uses the live request; otherwise the captured one.
  always_comb begin
    finish  = 1'b0;
    accWr   = opWr;
    accAddr = addrQ;
    accData = wdataQ;
    if (LATENCY == 1) begin
      finish  = accept;
      accWr   = req_wr;
      accAddr = addr;
      accData = wdata;
    end else if (state == BUSY && count == 4'd0) begin
      finish = 1'b1;
    end
  end

  assign accIdx = DEPTH_LOG2'(accAddr >> OFF);

`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);
  assign accMis = |(accAddr & OFF_MASK);
`else
  assign accMis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= 4'd0;
      opWr   <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      rdata  <= '0;
      done   <= 1'b0;
      errQ   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      errQ <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            opWr   <= req_wr;
            addrQ  <= addr;
            wdataQ <= wdata;
            if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              count <= CNT_INIT;
              state <= BUSY;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (count == 4'd0) state <= DONE;
          else count <= count - 4'd1;
        end
        default: state <= IDLE;
      endcase
      // Completion: a misaligned access only raises err and leaves storage and rdata untouched.
      if (finish) begin
        done <= 1'b1;
        if (accMis) errQ <= 1'b1;
        else if (accWr) mem[accIdx] <= accData;
        else rdata <= mem[accIdx];
      end
    end
  end

endmodule
